bm_ibuf_sched: RTL and testbench
================================

// Module: bm_ibuf_sched
// PURPOSE
// - Fill sequencer for the block-matching L/R line input buffer: splits each image line into memory
//   read bursts, gates each burst on the buffer's wr_rdy, and counts the data beats written into the buffer.
// - Per frame it drives the buffer's start, and per line its line_end and next_line.
// - Sits between the read-DMA command port and the line buffer; the disparity core is the line consumer.
// PARAMETERS
// - AW      32  byte-address width of rd_addr / base_addr
// - LNW     11  width of line counters (up to 2047 lines per frame)
// - STW     16  width of line stride (bytes)
// PORTS
// - clk        in   1     single clock; all logic on posedge
// - rst        in   1     reset; synchronous, active-high
// - start      in   1     frame start pulse; latches all parameters
// - line_size  in   9     words (32b) per line; 1..511
// - bst_len    in   9     max burst length in words; 64/128/256
// - num_lines  in   LNW   lines per frame
// - base_addr  in   AW    byte address of line 0 (word aligned)
// - stride     in   STW   byte distance between line starts
// - rd_req     out  1     burst request valid
// - rd_addr    out  AW    burst byte address
// - rd_len     out  9     burst length in words
// - rd_ack     in   1     request accepted this cycle
// - wr         in   1     data beat written into buffer this cycle
// - wr_rdy     in   1     buffer has space for one bst_len burst
// - rd_rdy     in   1     buffer holds at least one complete line
// - line_done  in   1     consumer finished current line (pulse)
// - buf_start  out  1     start pulse to buffer
// - line_end   out  1     last beat of a line has been written (pulse)
// - next_line  out  1     release one line in buffer (pulse)
// - busy       out  1     frame in progress
// - done       out  1     frame fully fetched and consumed (pulse)
// - err        out  1     sticky protocol error; cleared by start
// BEHAVIOUR
// - Reset: all outputs 0, FSM=IDLE, all counters 0.
// - Clock and reset: one clock; reset is synchronous and active-high.
// - FSM: IDLE -> REQ -> DATA -> (REQ | DRAIN) -> DONE -> IDLE.
// - start in any state (including mid-frame abort):
//   - next cycle buf_start=1 for 1 cycle; rd_req drops; err cleared.
//   - Latch params; addr=line_base=base_addr; wleft=line_size; lines_fetched=lines_used=0.
//   - Go to REQ, or to DONE if line_size==0 or num_lines==0.
// - REQ:
//   - rd_req=wr_rdy. rd_addr=addr. rd_len=min(bst_len,wleft). rd_addr/rd_len stable while rd_req=1.
//   - rd_req & rd_ack -> DATA; beat counter=rd_len.
// - DATA:
//   - Each wr decrements the beat counter and wleft; addr+=4 per beat.
//   - When the counter reaches 0 on a beat:
//     - If wleft==0: line_end=1 the next cycle. line_base+=stride (AW-bit wrap); addr=line_base+stride;
//       wleft=line_size; lines_fetched++.
//     - Then go to DRAIN if lines_fetched==num_lines, else REQ.
// - next_line = line_done & rd_rdy & (lines_used<lines_fetched), registered (1-cycle latency);
//   each pulse increments lines_used.
// - DRAIN: lines_used==num_lines -> DONE.
// - DONE: done=1 for 1 cycle -> IDLE.
// - busy=1 in REQ, DATA and DRAIN.
// - One outstanding burst only; rd_len never crosses a line end, so bursts are never split across lines.
// - Simultaneous line_end and next_line: both issue in the same cycle; counters update independently.
// - Errors (each sets err=1, no other effect):
//   - wr outside DATA; beats arriving after an abort are ignored.
//   - line_done when lines_used>=lines_fetched or rd_rdy=0; no next_line is issued.
// - Arithmetic: wleft and the beat counter are 9b; lines_* are LNW bits; address adds are AW bits, modulo.
// STRUCTURE
// - Shared package bm_pkg: FSM state encoding, BM_WORD_BYTES=4, min9() helper.
// - Single flat module; burst sizing/address generator may be split as bm_burst_gen (natural sub-module).
// TESTING
// - line_size=100, bst_len=64, num_lines=2, base=0x1000, stride=0x200:
//   - bursts (0x1000,64), (0x1100,36), (0x1200,64), (0x1300,36).
//   - line_end after beats 100 and 200.
// - wr_rdy=0 held 20 cycles in REQ -> rd_req stays 0; rises the cycle after wr_rdy=1.
// - After 2 lines, line_done x2 with rd_rdy=1 -> two next_line pulses, then done=1 once, busy=0.
// - line_done with lines_used==lines_fetched -> no next_line, err=1; next start clears err.
// - start mid-DATA (after 10 beats) -> buf_start pulse, rd_req reissued at base, stale wr beats set err only.
// - num_lines=0 -> no rd_req; done pulses 2 cycles after start.

Source files
------------

// File: rtl/bm_pkg.sv
// Shared types and helpers for the block-matching line-buffer fill sequencer.
package bm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int BM_WORD_BYTES = 4;

    function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bm_ibuf_sched.sv
// Fill sequencer for the L/R line input buffer: splits lines into read bursts,
// counts written beats, and hands completed lines to the consumer.
module bm_ibuf_sched
    import bm_pkg::*;
#(
    parameter int AW  = 32,
    parameter int LNW = 11,
    parameter int STW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [8:0]     line_size,
    input  logic [8:0]     bst_len,
    input  logic [LNW-1:0] num_lines,
    input  logic [AW-1:0]  base_addr,
    input  logic [STW-1:0] stride,
    output logic           rd_req,
    output logic [AW-1:0]  rd_addr,
    output logic [8:0]     rd_len,
    input  logic           rd_ack,
    input  logic           wr,
    input  logic           wr_rdy,
    input  logic           rd_rdy,
    input  logic           line_done,
    output logic           buf_start,
    output logic           line_end,
    output logic           next_line,
    output logic           busy,
    output logic           done,
    output logic           err
);

    // rd_req/rd_ack is a valid/ready pair: once rd_req rises, rd_addr and rd_len
    // hold until the cycle rd_ack is seen with rd_req high.
    state_t         state;
    state_t         state_next;
    logic [8:0]     line_size_q;
    logic [8:0]     bst_len_q;
    logic [LNW-1:0] num_lines_q;
    logic [STW-1:0] stride_q;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  line_base;
    logic [8:0]     wleft;
    logic [8:0]     beat_cnt;
    logic [LNW-1:0] lines_fetched;
    logic [LNW-1:0] lines_used;
    logic [LNW-1:0] fetched_inc;
    logic [AW-1:0]  next_base;
    logic           frame_empty;
    logic           burst_last;
    logic           line_last;
    logic           nl_ok;

    assign frame_empty = (line_size == 9'd0) || (num_lines == '0);
    assign burst_last  = (state == ST_DATA) && wr && (beat_cnt == 9'd1);
    assign line_last   = burst_last && (wleft == 9'd1);
    assign fetched_inc = lines_fetched + LNW'(1);
    assign next_base   = line_base + AW'(stride_q);
    assign nl_ok       = line_done && rd_rdy && (lines_used < lines_fetched);

    assign rd_addr = addr;
    assign rd_len  = min9(bst_len_q, wleft);
    assign busy    = (state == ST_REQ) || (state == ST_DATA) || (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start) begin
            state_next = frame_empty ? ST_DONE : ST_REQ;
        end else begin
            case (state)
                ST_REQ:   if (rd_req && rd_ack) state_next = ST_DATA;
                ST_DATA:  if (burst_last)
                              state_next = (line_last && fetched_inc == num_lines_q) ? ST_DRAIN : ST_REQ;
                ST_DRAIN: if (lines_used == num_lines_q) state_next = ST_DONE;
                ST_DONE:  state_next = ST_IDLE;
                default:  state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line_size_q   <= '0;
            bst_len_q     <= '0;
            num_lines_q   <= '0;
            stride_q      <= '0;
            addr          <= '0;
            line_base     <= '0;
            wleft         <= '0;
            beat_cnt      <= '0;
            lines_fetched <= '0;
            lines_used    <= '0;
            rd_req        <= 1'b0;
            buf_start     <= 1'b0;
            line_end      <= 1'b0;
            next_line     <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            buf_start <= start;
            line_end  <= 1'b0;
            next_line <= 1'b0;
            done      <= 1'b0;
            if (start) begin
                line_size_q   <= line_size;
                bst_len_q     <= bst_len;
                num_lines_q   <= num_lines;
                stride_q      <= stride;
                addr          <= base_addr;
                line_base     <= base_addr;
                wleft         <= line_size;
                beat_cnt      <= '0;
                lines_fetched <= '0;
                lines_used    <= '0;
                rd_req        <= 1'b0;
                err           <= 1'b0;
            end else begin
                done <= (state == ST_DONE);
                if (state == ST_REQ) begin
                    if (rd_req && rd_ack) begin
                        rd_req   <= 1'b0;
                        beat_cnt <= rd_len;
                    end else if (!rd_req) begin
                        rd_req <= wr_rdy;
                    end
                end else begin
                    rd_req <= 1'b0;
                end
                if (wr && state == ST_DATA) begin
                    beat_cnt <= beat_cnt - 9'd1;
                    wleft    <= wleft - 9'd1;
                    addr     <= addr + AW'(BM_WORD_BYTES);
                    // Last beat of a line: jump to the next line start rather than the beat address.
                    if (line_last) begin
                        line_end      <= 1'b1;
                        line_base     <= next_base;
                        addr          <= next_base;
                        wleft         <= line_size_q;
                        lines_fetched <= fetched_inc;
                    end
                end
                if (nl_ok) begin
                    next_line  <= 1'b1;
                    lines_used <= lines_used + LNW'(1);
                end
                if ((wr && state != ST_DATA) || (line_done && !nl_ok)) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bm_ibuf_sched.sv
// Randomized self-checking bench for bm_ibuf_sched with a burst-list reference model.
module tb_bm_ibuf_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  line_size;
    logic [8:0]  bst_len;
    logic [10:0] num_lines;
    logic [31:0] base_addr;
    logic [15:0] stride;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [8:0]  rd_len;
    logic        rd_ack;
    logic        wr;
    logic        wr_rdy;
    logic        rd_rdy;
    logic        line_done;
    logic        buf_start;
    logic        line_end;
    logic        next_line;
    logic        busy;
    logic        done;
    logic        err;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [40:0] exp_q[$];

    bm_ibuf_sched #(.AW(32), .LNW(11), .STW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .line_size(line_size), .bst_len(bst_len),
        .num_lines(num_lines), .base_addr(base_addr), .stride(stride),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ack(rd_ack),
        .wr(wr), .wr_rdy(wr_rdy), .rd_rdy(rd_rdy), .line_done(line_done),
        .buf_start(buf_start), .line_end(line_end), .next_line(next_line),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_start(input int ls, input int bl, input int nl,
                               input logic [31:0] base, input logic [15:0] strd);
        @(negedge clk);
        start     = 1'b1;
        line_size = 9'(ls);
        bst_len   = 9'(bl);
        num_lines = 11'(nl);
        base_addr = base;
        stride    = strd;
        wr        = 1'b0;
        rd_ack    = 1'b0;
        line_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 10 && rd_req !== 1'b1; i++) @(negedge clk);
        vec_cnt++;
        if (rd_req !== 1'b1) begin
            miss_cnt++;
            $display("FAIL wait_req: rd_req=%b required 1 within 10 cycles", rd_req);
        end
    endtask

    // Full frame with a DMA/consumer emulation; expected bursts come from line geometry.
    task automatic run_frame(input int ls, input int bl, input int nl,
                             input logic [31:0] base, input logic [15:0] strd, input int hold);
        int off, rem, len, beats_total, beats_done, burst_left, fetched, used, cyc;
        logic le_exp, nl_exp, got_done;
        logic [31:0] a;
        logic [40:0] ent;
        exp_q.delete();
        for (int l = 0; l < nl; l++) begin
            off = 0;
            while (off < ls) begin
                rem = ls - off;
                len = (rem < bl) ? rem : bl;
                a = base + 32'(l) * 32'(strd) + 32'(off * 4);
                exp_q.push_back({a, 9'(len)});
                off += len;
            end
        end
        wr_rdy = (hold == 0);
        rd_rdy = 1'b1;
        apply_start(ls, bl, nl, base, strd);
        vec_cnt++;
        if (buf_start !== 1'b1) begin
            miss_cnt++;
            $display("FAIL buf_start: got %b required 1", buf_start);
        end
        vec_cnt++;
        if (err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL err_cleared: got %b required 0", err);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                vec_cnt++;
                if (rd_req !== 1'b0) begin
                    miss_cnt++;
                    $display("FAIL rd_req_hold: cycle %0d got %b required 0", i, rd_req);
                end
                @(negedge clk);
            end
            wr_rdy = 1'b1;
            @(negedge clk);
            vec_cnt++;
            if (rd_req !== 1'b1) begin
                miss_cnt++;
                $display("FAIL rd_req_rise: got %b required 1", rd_req);
            end
        end
        beats_total = ls * nl;
        beats_done = 0; burst_left = 0; fetched = 0; used = 0; cyc = 0;
        le_exp = 1'b0; nl_exp = 1'b0; got_done = 1'b0;
        while (!got_done && cyc < 20000) begin
            vec_cnt++;
            if (line_end !== le_exp) begin
                miss_cnt++;
                $display("FAIL line_end: beat %0d got %b required %b", beats_done, line_end, le_exp);
            end
            vec_cnt++;
            if (next_line !== nl_exp) begin
                miss_cnt++;
                $display("FAIL next_line: used %0d got %b required %b", used, next_line, nl_exp);
            end
            if (le_exp) fetched++;
            if (nl_exp) used++;
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                if (beats_done < beats_total) begin
                    vec_cnt++;
                    if (busy !== 1'b1) begin
                        miss_cnt++;
                        $display("FAIL busy: got %b required 1", busy);
                    end
                end
                if (burst_left > 0) begin
                    vec_cnt++;
                    if (rd_req !== 1'b0) begin
                        miss_cnt++;
                        $display("FAIL outstanding: rd_req=%b required 0 during burst", rd_req);
                    end
                end
                rd_ack = 1'b0; wr = 1'b0; line_done = 1'b0;
                le_exp = 1'b0; nl_exp = 1'b0;
                wr_rdy = ($urandom_range(0, 3) != 0);
                if (burst_left > 0) begin
                    if ($urandom_range(0, 3) != 0) begin
                        wr = 1'b1;
                        burst_left--;
                        beats_done++;
                        if (beats_done % ls == 0) le_exp = 1'b1;
                    end
                end else if (rd_req === 1'b1 && $urandom_range(0, 1) == 1) begin
                    vec_cnt++;
                    if (exp_q.size() == 0) begin
                        miss_cnt++;
                        $display("FAIL extra_burst: addr=%h len=%0d required none", rd_addr, rd_len);
                    end else begin
                        ent = exp_q.pop_front();
                        if ({rd_addr, rd_len} !== ent) begin
                            miss_cnt++;
                            $display("FAIL burst: got addr=%h len=%0d required addr=%h len=%0d",
                                     rd_addr, rd_len, ent[40:9], ent[8:0]);
                        end
                        burst_left = int'(ent[8:0]);
                    end
                    rd_ack = 1'b1;
                end
                if (used < fetched && $urandom_range(0, 2) == 0) begin
                    line_done = 1'b1;
                    nl_exp = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        rd_ack = 1'b0; wr = 1'b0; line_done = 1'b0;
        vec_cnt++;
        if (!got_done) begin
            miss_cnt++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
        end else if (fetched != nl || used != nl || beats_done != beats_total || exp_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL done_early: fetched=%0d used=%0d beats=%0d left=%0d required lines=%0d beats=%0d",
                     fetched, used, beats_done, exp_q.size(), nl, beats_total);
        end
        vec_cnt++;
        if ({busy, err} !== 2'b00) begin
            miss_cnt++;
            $display("FAIL end_state: busy=%b err=%b required 0 0", busy, err);
        end
        @(negedge clk);
        vec_cnt++;
        if (done !== 1'b0) begin
            miss_cnt++;
            $display("FAIL done_pulse: got %b required 0 after one cycle", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; line_size = '0; bst_len = '0; num_lines = '0;
        base_addr = '0; stride = '0; rd_ack = 1'b0; wr = 1'b0; wr_rdy = 1'b0;
        rd_rdy = 1'b0; line_done = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if ({rd_req, buf_start, line_end, next_line, busy, done, err} !== 7'b0) begin
            miss_cnt++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {rd_req, buf_start, line_end, next_line, busy, done, err});
        end
        vec_cnt++;
        if ({rd_addr, rd_len} !== 41'b0) begin
            miss_cnt++;
            $display("FAIL reset_bus: addr=%h len=%0d required 0 0", rd_addr, rd_len);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_spec_frame();
        run_frame(100, 64, 2, 32'h0000_1000, 16'h0200, 0);
    endtask

    task automatic test_wr_rdy_hold();
        run_frame(100, 64, 2, 32'h0000_1000, 16'h0200, 20);
    endtask

    task automatic test_line_done_err();
        rd_rdy = 1'b1;
        line_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
        vec_cnt++;
        if ({next_line, err} !== 2'b01) begin
            miss_cnt++;
            $display("FAIL idle_line_done: next_line=%b err=%b required 0 1", next_line, err);
        end
        wr_rdy = 1'b1;
        apply_start(4, 64, 2, 32'h0000_2000, 16'h0040);
        vec_cnt++;
        if (err !== 1'b0) begin
            miss_cnt++;
            $display("FAIL start_clears_err: got %b required 0", err);
        end
        wait_req();
        vec_cnt++;
        if ({rd_addr, rd_len} !== {32'h0000_2000, 9'd4}) begin
            miss_cnt++;
            $display("FAIL short_burst: addr=%h len=%0d required 00002000 4", rd_addr, rd_len);
        end
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr = 1'b1;
            @(negedge clk);
        end
        wr = 1'b0;
        vec_cnt++;
        if (line_end !== 1'b1) begin
            miss_cnt++;
            $display("FAIL short_line_end: got %b required 1", line_end);
        end
        line_done = 1'b1; rd_rdy = 1'b0;
        @(negedge clk);
        line_done = 1'b0; rd_rdy = 1'b1;
        vec_cnt++;
        if ({next_line, err} !== 2'b01) begin
            miss_cnt++;
            $display("FAIL rd_rdy_low: next_line=%b err=%b required 0 1", next_line, err);
        end
        line_done = 1'b1;
        @(negedge clk);
        line_done = 1'b0;
        vec_cnt++;
        if (next_line !== 1'b1) begin
            miss_cnt++;
            $display("FAIL release_line: next_line=%b required 1", next_line);
        end
    endtask

    task automatic test_zero_lines();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) apply_start(10, 64, 0, 32'h0000_3000, 16'h0100);
            else        apply_start(0, 64, 3, 32'h0000_3000, 16'h0100);
            vec_cnt++;
            if ({buf_start, rd_req, busy, done, err} !== 5'b10000) begin
                miss_cnt++;
                $display("FAIL empty_t1[%0d]: buf_start/rd_req/busy/done/err=%b required 10000",
                         k, {buf_start, rd_req, busy, done, err});
            end
            @(negedge clk);
            vec_cnt++;
            if ({rd_req, busy, done} !== 3'b001) begin
                miss_cnt++;
                $display("FAIL empty_t2[%0d]: rd_req/busy/done=%b required 001", k, {rd_req, busy, done});
            end
            @(negedge clk);
            vec_cnt++;
            if ({rd_req, done} !== 2'b00) begin
                miss_cnt++;
                $display("FAIL empty_t3[%0d]: rd_req/done=%b required 00", k, {rd_req, done});
            end
        end
    endtask

    task automatic test_abort();
        wr_rdy = 1'b1; rd_rdy = 1'b1;
        apply_start(100, 64, 1, 32'h0000_8000, 16'h0100);
        wait_req();
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wr = 1'b1;
            @(negedge clk);
        end
        wr = 1'b0;
        apply_start(100, 64, 1, 32'h0000_9000, 16'h0100);
        vec_cnt++;
        if ({buf_start, rd_req, err} !== 3'b100) begin
            miss_cnt++;
            $display("FAIL abort_t1: buf_start/rd_req/err=%b required 100", {buf_start, rd_req, err});
        end
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        vec_cnt++;
        if ({rd_req, err} !== 2'b11) begin
            miss_cnt++;
            $display("FAIL abort_stale: rd_req/err=%b required 11", {rd_req, err});
        end
        vec_cnt++;
        if ({rd_addr, rd_len} !== {32'h0000_9000, 9'd64}) begin
            miss_cnt++;
            $display("FAIL abort_reissue: addr=%h len=%0d required 00009000 64", rd_addr, rd_len);
        end
    endtask

    task automatic test_random_frames();
        int bl;
        for (int f = 0; f < 6; f++) begin
            case ($urandom_range(0, 2))
                0:       bl = 64;
                1:       bl = 128;
                default: bl = 256;
            endcase
            run_frame(int'($urandom_range(1, 160)), bl, int'($urandom_range(1, 3)),
                      {$urandom()} & 32'hFFFF_FFFC, 16'($urandom()) & 16'hFFFC, 0);
        end
        run_frame(511, 256, 1, 32'hFFFF_FF00, 16'h0800, 0);
    endtask

    initial begin
        test_reset();
        test_spec_frame();
        test_wr_rdy_hold();
        test_line_done_err();
        test_zero_lines();
        test_abort();
        test_zero_lines();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
